// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller:
// hex segment table, slot timing arithmetic and leading-zero suppression.
package seg7_pkg;

  localparam int PHASES     = 16;
  localparam int MAX_DIGITS = 16;

  // gfedcba, active-high, indexed by nibble value
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Sub-counter modulus and width for a given digit-slot length.
  function automatic int sub_div(input int refresh_div);
    return refresh_div / PHASES;
  endfunction

  function automatic int cnt_w(input int refresh_div);
    return $clog2(refresh_div / PHASES);
  endfunction

  // Bit k set when digit k and every digit above it are zero; digit 0 is never suppressed.
  // Unused upper nibbles must be zero so they do not break the run of zeros.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] data,
                                                    input logic                    lz_en);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (data[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_en & all_zero;
    end
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Hex nibble to seven-segment pattern (gfedcba, active-high); purely combinational.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadowed tear-free loads, per-digit dp and
// blanking, leading-zero suppression and 16-level brightness PWM within each digit slot.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_load,
  input  logic [4*DIGITS-1:0]   I_data,
  input  logic [DIGITS-1:0]     I_dp,
  input  logic [DIGITS-1:0]     I_blank,
  input  logic                  I_lz_en,
  input  logic [3:0]            I_bright,
  output logic [6:0]            O_seg,
  output logic                  O_dp,
  output logic [DIGITS-1:0]     O_dig,
  output logic                  O_frame
);

  localparam int SUB_DIV = sub_div(REFRESH_DIV);
  localparam int CNT_W   = cnt_w(REFRESH_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz_en;
  } disp_t;

  disp_t             shadow;
  disp_t             active;
  logic [CNT_W-1:0]  sub_cnt;
  logic [3:0]        phase;
  logic [IDX_W-1:0]  idx;

  logic              sub_tc;
  logic              slot_end;
  logic              idx_last;
  logic [DIGITS-1:0] lz_vec;
  logic [3:0]        nibble;
  logic [6:0]        pattern;

  logic              lit;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] dig_d;
  logic              frame_d;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] dig_q;
  logic              frame_q;

  assign sub_tc   = (sub_cnt == CNT_W'(SUB_DIV - 1));
  assign slot_end = sub_tc && (phase == 4'hF);
  assign idx_last = (idx == IDX_W'(DIGITS - 1));

  // Suppression is judged on what is on screen, never on the pending shadow value.
  assign lz_vec = DIGITS'(lz_mask((4*MAX_DIGITS)'(active.data), active.lz_en));
  assign nibble = active.data[4*idx +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (pattern)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    seg_d   = '0;
    dp_d    = 1'b0;
    dig_d   = '0;
    lit     = (phase <= I_bright) && !active.blank[idx] && !lz_vec[idx];
    frame_d = slot_end && idx_last;
    if (lit) begin
      seg_d      = pattern;
      dp_d       = active.dp[idx];
      dig_d[idx] = 1'b1;
    end
  end

  // Slot timing and the shadow/active display registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      // NOTE: shadow and active are ordinary flops, so they reset; no memory is inferred here.
      sub_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
    end else begin
      // NOTE: non-blocking updates let active take the pre-edge shadow when a load hits a boundary.
      sub_cnt <= sub_tc ? '0 : sub_cnt + 1'b1;
      if (sub_tc) begin
        phase <= phase + 4'd1;
      end
      if (slot_end) begin
        idx    <= idx_last ? '0 : idx + 1'b1;
        active <= shadow;
      end
      if (I_load) begin
        shadow <= '{data: I_data, dp: I_dp, blank: I_blank, lz_en: I_lz_en};
      end
    end
  end

  // Pin registers; they trail the index/phase by one cycle.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign O_seg   = seg_q ^ {7{SEG_ACT_LOW}};
  assign O_dp    = dp_q ^ SEG_ACT_LOW;
  assign O_dig   = dig_q ^ {DIGITS{DIG_ACT_LOW}};
  assign O_frame = frame_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller, successor to the fixed 2-digit driver. It drives DIGITS hex digits with per-digit decimal points, blanking, leading-zero suppression and 16-level brightness PWM. New data is loaded with a strobe into a shadow register and takes effect only at a digit-slot boundary, so the display never tears. It sits between the CPU's memory-mapped display register and the board's segment and anode pins.

Parameters:
- DIGITS, 8: number of digits, legal range 1..16.
- REFRESH_DIV, 100000: I_clk cycles per digit slot; must be a multiple of 16 and ≥ 32.
- SEG_ACT_LOW, 0: 1 inverts O_seg and O_dp at the pins.
- DIG_ACT_LOW, 0: 1 inverts O_dig at the pins.

Ports:
- I_clk  in  1  system clock.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_load  in  1  one-cycle strobe; captures I_data, I_dp, I_blank, I_lz_en into the shadow register.
- I_data  in  4*DIGITS  hex nibbles; digit k uses I_data[4k+3:4k]; digit 0 is least significant.
- I_dp  in  DIGITS  decimal-point enable per digit.
- I_blank  in  DIGITS  force digit k dark.
- I_lz_en  in  1  enable leading-zero suppression.
- I_bright  in  4  brightness level; 0 is dimmest (1/16 duty), 15 is full duty.
- O_seg  out  7  segments; bit0=a … bit6=g.
- O_dp  out  1  decimal-point segment.
- O_dig  out  DIGITS  one-hot digit enable.
- O_frame  out  1  one-cycle pulse when the scan wraps from DIGITS-1 to 0.

Behaviour:
- Reset (async): slot counter = 0, digit index = 0, shadow and active registers = 0, all outputs inactive. Inactive means logical O_seg = 0, O_dp = 0, O_dig = 0, O_frame = 0, before the polarity parameters are applied.
- Slot timing: a sub-counter counts 0..REFRESH_DIV/16−1. At its terminal count the 4-bit phase register increments. When the phase wraps 15→0 (end of slot):
  - the digit index advances, wrapping DIGITS−1 → 0;
  - the active register is loaded from the shadow register;
  - if the index wrapped, O_frame pulses for exactly one cycle.
- Load: on I_load at cycle t, the shadow register holds the new values from t+1. They become visible at the first slot boundary after t+1. Repeated I_load before that boundary: the last one wins. An I_load in the same cycle as a boundary lands in the shadow only and is shown at the following boundary.
- Leading-zero suppression: computed from the active register. When lz_en = 1, digit k (k ≥ 1) is suppressed if its nibble and every higher nibble are all 0. Digit 0 is never suppressed, so value 0 still shows "0".
- Blank condition for the current digit: blank bit set OR suppressed.
- Segment decode (gfedcba, active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Outputs are registered, so they trail the index/phase by 1 cycle.
- Digit on condition: phase ≤ I_bright AND not blanked.
  - Digit on: O_dig = one-hot(index), O_seg = decode(nibble), O_dp = dp bit.
  - Digit off: O_dig = 0, O_seg = 0, O_dp = 0.
  - I_bright is sampled live every cycle; changing it mid-slot is legal.
- DIGITS = 1: the index stays at 0 and O_frame pulses at every slot end.
- Polarity inversion is applied after the output registers, by XOR with the parameter.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry SEG7_HEX constant table;
  - localparams SUB_DIV = REFRESH_DIV/16 and CNT_W = $clog2(SUB_DIV);
  - the function lz_mask(data, lz_en), returning the suppression vector.
- One sub-module, seg7_decode: 4-bit nibble in, 7-bit pattern out, purely combinational from the table.
- All timing, shadowing and muxing stay in seg7_scan_ctrl.

Test Plan:
- Reset and scan cadence. Config DIGITS=4, REFRESH_DIV=32, bright=15, load data=16'h1234 (no blanking, no leading-zero suppression, matching the next scenario), then release reset.
  - Required: O_dig steps 0001→0010→0100→1000 every 32 cycles.
  - Required: O_seg = 4F, 5B, 06 for digits 1..3 and 66 for digit 0 (value 4).
  - Required: O_frame pulses once per 128 cycles.
- Tear-free load. Mid-slot while digit 2 is lit, pulse I_load with data=16'hABCD.
  - Required: the current slot completes with 5B; the next slot (digit 3) shows 77 (A).
  - Required: two loads within one slot → only the second value appears.
- Leading-zero and blanking. Load data=16'h0050 with lz_en=1.
  - Required: digits 3 and 2 dark, digit 1 = 6D, digit 0 = 3F.
  - Load data=16'h0000 → only digit 0 lit with 3F.
  - Load I_blank=4'b0001 → digit 0 dark.
- Brightness. Set bright=3.
  - Required: within each slot, O_dig is active for the first 8 cycles (phases 0–3, SUB_DIV=2) and 0 for the remaining 24.
  - Set bright=0 → 2 active cycles per slot.
- Decimal point and polarity. Config SEG_ACT_LOW=1, DIG_ACT_LOW=1, I_dp=4'b0100.
  - Required: O_dp = 0 only while digit 2 is lit.
  - Required: during reset, O_seg = 7F and O_dig = all ones.
- Async reset mid-scan. Assert I_rst_n low during digit 3.
  - Required: outputs go inactive in the same cycle without waiting for a clock edge.
  - Required: after release, the scan restarts at digit 0 and the shadow register reads back 0.
